// File: rtl/conv_pkg.sv
// Shared definitions for the sliding-window address generator.
//   - state_t   : scan FSM states
//   - K_DEF, ADDR_WIDTH_DEF, IDX_W : default window side, address width and
//                 window-index width
//   - port_lsb  : bit offset of read port p inside the flattened address bus
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int K_DEF          = 5;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int IDX_W          = 16;

    function automatic int port_lsb(input int p, input int aw);
        return p * aw;
    endfunction

endpackage

// File: rtl/win_addr_calc.sv
// Combinational K*K window address calculator.
//   base : word address of map pixel (0,0)
//   row  : output-row index of the window
//   col  : output-column index of the window
//   addr : K*K flattened addresses; port p = i*K+j at [port_lsb(p)+:ADDR_WIDTH]
// addr(i,j) = base + (row*STRIDE+i)*IMG_W + col*STRIDE + j  (mod 2^ADDR_WIDTH)
module win_addr_calc
    import conv_pkg::*;
#(
    parameter int IMG_W      = 32,
    parameter int K          = K_DEF,
    parameter int STRIDE     = 1,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0]       base,
    input  logic [IDX_W-1:0]            row,
    input  logic [IDX_W-1:0]            col,
    output logic [K*K*ADDR_WIDTH-1:0]   addr
);

    // Top-left pixel of the window; every port is a constant offset from it.
    logic [ADDR_WIDTH-1:0] top_left;

    assign top_left = base
                    + ADDR_WIDTH'(row) * ADDR_WIDTH'(STRIDE * IMG_W)
                    + ADDR_WIDTH'(col) * ADDR_WIDTH'(STRIDE);

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            localparam int LSB = port_lsb(i * K + j, ADDR_WIDTH);
            assign addr[LSB +: ADDR_WIDTH] = top_left + ADDR_WIDTH'(i * IMG_W + j);
        end
    end

endmodule

// File: rtl/conv_win_addr_gen.sv
// Sliding-window read-address generator for the K*K-port feature-map buffer.
// Scans a KxK window row-major over an IMG_W x IMG_H map, one window per
// accepted beat, and tracks the buffer's one-cycle read latency so that
// data_valid lines up with the buffer's read data.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         pulse to begin a full-map scan (ignored unless idle)
//   base_addr     word address of pixel (0,0), latched on accepted start
//   rd_addr_NP    K*K read addresses, port p=i*K+j at [(p+1)*AW-1 : p*AW]
//   data_valid    buffer data this cycle belongs to (win_row, win_col)
//   out_ready     consumer accepts the current window
//   win_row/col   window index in the data stage
//   last          high with data_valid on the final window
//   busy          scan in progress
//   done          one-cycle pulse after the final window is accepted
//   err_oob       (only with CONV_ADDR_BOUND_CHK_EN) sticky flag, set when an
//                 issued address is >= DEPTH; cleared by reset/accepted start
module conv_win_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = K_DEF,
    parameter int STRIDE     = 1,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic [K*K*ADDR_WIDTH-1:0] rd_addr_NP,
    output logic                      data_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          win_row,
    output logic [IDX_W-1:0]          win_col,
    output logic                      last,
    output logic                      busy,
    output logic                      done
`ifdef CONV_ADDR_BOUND_CHK_EN
    ,
    output logic                      err_oob
`endif
);

    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(OUT_W - 1);
    localparam logic [IDX_W-1:0] LAST_R = IDX_W'(OUT_H - 1);

    state_t                state;
    logic [IDX_W-1:0]      cur_r, cur_c;
    logic [IDX_W-1:0]      nxt_r, nxt_c;
    logic [IDX_W-1:0]      sel_r, sel_c;
    logic [ADDR_WIDTH-1:0] base;
    logic                  adv;
    logic                  nxt_is_last;

    // A window moves into the data stage whenever the stage is empty or its
    // current occupant is being accepted.
    assign adv         = (state == RUN) && (!data_valid || out_ready);
    assign nxt_is_last = (nxt_r == LAST_R) && (nxt_c == LAST_C);

    // Present the next window while advancing, otherwise re-read the current
    // one so the buffer output stays stable under backpressure.
    assign sel_r = adv ? nxt_r : cur_r;
    assign sel_c = adv ? nxt_c : cur_c;

    assign win_row = cur_r;
    assign win_col = cur_c;

    win_addr_calc #(
        .IMG_W      (IMG_W),
        .K          (K),
        .STRIDE     (STRIDE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_calc (
        .base (base),
        .row  (sel_r),
        .col  (sel_c),
        .addr (rd_addr_NP)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_r      <= '0;
            cur_c      <= '0;
            nxt_r      <= '0;
            nxt_c      <= '0;
            base       <= '0;
            data_valid <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base       <= base_addr;
                        nxt_r      <= '0;
                        nxt_c      <= '0;
                        data_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        cur_r      <= nxt_r;
                        cur_c      <= nxt_c;
                        data_valid <= 1'b1;
                        last       <= nxt_is_last;
                        if (nxt_is_last) begin
                            state <= DRAIN;
                        end else if (nxt_c == LAST_C) begin
                            nxt_c <= '0;
                            nxt_r <= nxt_r + 1'b1;
                        end else begin
                            nxt_c <= nxt_c + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        data_valid <= 1'b0;
                        last       <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_ADDR_BOUND_CHK_EN
    logic any_oob;

    always_comb begin
        any_oob = 1'b0;
        for (int p = 0; p < K * K; p++) begin
            if (rd_addr_NP[port_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH] >= ADDR_WIDTH'(DEPTH))
                any_oob = 1'b1;
        end
    end

    // Only addresses actually issued (adv high) count; stalled re-reads of an
    // already-issued window would flag the same thing again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_oob <= 1'b0;
        else if (state == IDLE && start)
            err_oob <= 1'b0;
        else if (adv && any_oob)
            err_oob <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_conv_win_addr_gen.sv
module tb_conv_win_addr_gen;
    import conv_pkg::*;

    localparam int AW = 32;
    localparam int KK = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b1;
    logic sel_b = 1'b0;
    logic [AW-1:0] base = '0;
    logic start_a, start_b;

    logic [KK*AW-1:0] rd_a, rd_b;
    logic dv_a, dv_b, last_a, last_b, busy_a, busy_b, done_a, done_b;
    logic [IDX_W-1:0] wr_a, wc_a, wr_b, wc_b;
`ifdef CONV_ADDR_BOUND_CHK_EN
    logic err_a, err_b;
`endif

    // Outputs of whichever DUT the current scan targets.
    logic s_dv, s_last, s_busy, s_done;
    logic [IDX_W-1:0] s_r, s_c;
    logic [AW-1:0] s_p0, s_p24;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel_b;
    assign start_b = start & sel_b;

    conv_win_addr_gen #(
        .IMG_W(7), .IMG_H(7), .K(5), .STRIDE(1), .ADDR_WIDTH(AW), .DEPTH(1024)
    ) u_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base),
        .rd_addr_NP(rd_a), .data_valid(dv_a), .out_ready(ready),
        .win_row(wr_a), .win_col(wc_a), .last(last_a), .busy(busy_a), .done(done_a)
`ifdef CONV_ADDR_BOUND_CHK_EN
        , .err_oob(err_a)
`endif
    );

    conv_win_addr_gen #(
        .IMG_W(9), .IMG_H(9), .K(5), .STRIDE(2), .ADDR_WIDTH(AW), .DEPTH(1024)
    ) u_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base),
        .rd_addr_NP(rd_b), .data_valid(dv_b), .out_ready(ready),
        .win_row(wr_b), .win_col(wc_b), .last(last_b), .busy(busy_b), .done(done_b)
`ifdef CONV_ADDR_BOUND_CHK_EN
        , .err_oob(err_b)
`endif
    );

    always_comb begin
        if (sel_b) begin
            s_dv = dv_b; s_last = last_b; s_busy = busy_b; s_done = done_b;
            s_r = wr_b; s_c = wc_b; s_p0 = rd_b[0 +: AW]; s_p24 = rd_b[24*AW +: AW];
        end else begin
            s_dv = dv_a; s_last = last_a; s_busy = busy_a; s_done = done_a;
            s_r = wr_a; s_c = wc_a; s_p0 = rd_a[0 +: AW]; s_p24 = rd_a[24*AW +: AW];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One full scan. w/s/ow: image width, stride, output-grid side (square).
    // stall_win: hold ready low 3 cycles on that window; restart_win: pulse
    // start (with a different base) on that window; rst_win: reset there.
    task automatic scan(input logic [31:0] b, input int w, input int s, input int ow,
                        input int stall_win, input int restart_win, input int rst_win,
                        input string tg);
        int acc, er, ec, stall_n, dones;
        bit last_acc, seen_done;
        logic [31:0] p0_prev, p24_prev, e0;
        acc = 0; er = 0; ec = 0; stall_n = 0; dones = 0;
        last_acc = 0; seen_done = 0;
        @(negedge clk); start = 1'b1; base = b; ready = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk({tg, ":busy_start"}, 32'(s_busy), 1);
        chk({tg, ":dv_start"}, 32'(s_dv), 0);
`ifdef CONV_ADDR_BOUND_CHK_EN
        if (!sel_b) chk({tg, ":err_clr"}, 32'(err_a), 0);
`endif
        p0_prev = s_p0; p24_prev = s_p24;
        for (int cyc = 0; cyc < 80 && !seen_done; cyc++) begin
            @(negedge clk);
            ready = 1'b1; start = 1'b0;
            if (s_dv && acc == stall_win && stall_n < 3) begin
                ready = 1'b0; stall_n++;
            end
            if (s_dv && acc == restart_win) begin
                start = 1'b1; base = b + 500;
            end
            if (s_dv && acc == rst_win) begin
                rst = 1'b1; #1;
                chk({tg, ":rst_dv"}, 32'(s_dv), 0);
                chk({tg, ":rst_busy"}, 32'(s_busy), 0);
                chk({tg, ":rst_last"}, 32'(s_last), 0);
                chk({tg, ":rst_done"}, 32'(s_done), 0);
                chk({tg, ":rst_row"}, 32'(s_r), 0);
                chk({tg, ":rst_col"}, 32'(s_c), 0);
                @(negedge clk); rst = 1'b0; start = 1'b0; base = b;
                return;
            end
            #1;
            if (s_done) begin
                dones++; seen_done = 1;
                chk({tg, ":done_after_last"}, 32'(last_acc), 1);
                chk({tg, ":done_dv"}, 32'(s_dv), 0);
                chk({tg, ":done_busy"}, 32'(s_busy), 0);
            end
            if (s_dv) begin
                e0 = b + 32'(er * s * w + ec * s);
                chk({tg, ":row"}, 32'(s_r), 32'(er));
                chk({tg, ":col"}, 32'(s_c), 32'(ec));
                chk({tg, ":port0"}, p0_prev, e0);
                chk({tg, ":port24"}, p24_prev, e0 + 32'(4 * w + 4));
                chk({tg, ":last"}, 32'(s_last), 32'(acc == ow * ow - 1));
                if (!ready) chk({tg, ":stall_hold"}, s_p0, e0);
                last_acc = ready && s_last;
                if (ready) begin
                    acc++;
                    if (ec == ow - 1) begin ec = 0; er++; end
                    else ec++;
                end
            end else begin
                last_acc = 0;
            end
            p0_prev = s_p0; p24_prev = s_p24;
        end
        start = 1'b0; base = b;
        chk({tg, ":done_seen"}, 32'(seen_done), 1);
        repeat (3) begin
            @(negedge clk); #1;
            if (s_done) dones++;
        end
        chk({tg, ":beats"}, 32'(acc), 32'(ow * ow));
        chk({tg, ":dones"}, 32'(dones), 1);
        chk({tg, ":idle_busy"}, 32'(s_busy), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset:dv", 32'(dv_a), 0);
        chk("reset:busy", 32'(busy_a), 0);
        chk("reset:done", 32'(done_a), 0);
        chk("reset:last", 32'(last_a), 0);
        chk("reset:row", 32'(wr_a), 0);
        chk("reset:col", 32'(wc_a), 0);
        chk("reset:port0", rd_a[0 +: AW], 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("idle:dv", 32'(dv_a), 0);

        sel_b = 1'b0;
        scan(0, 7, 1, 3, -1, -1, -1, "basic");
        scan(0, 7, 1, 3, 3, -1, -1, "stall");
        sel_b = 1'b1;
        scan(100, 9, 2, 3, -1, -1, -1, "stride2");
        sel_b = 1'b0;
        scan(0, 7, 1, 3, -1, 4, -1, "restart");
        scan(0, 7, 1, 3, -1, -1, 5, "reset");
        scan(0, 7, 1, 3, -1, -1, -1, "rescan");
`ifdef CONV_ADDR_BOUND_CHK_EN
        scan(1000, 7, 1, 3, -1, -1, -1, "oob");
        chk("oob:err_set", 32'(err_a), 1);
        scan(0, 7, 1, 3, -1, -1, -1, "oob_clr");
        chk("oob_clr:err", 32'(err_a), 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
